// File: rtl/wb_calc_e_host.sv
// wb_calc_e_host: Wishbone classic master that runs one calc_e job per start.
// A job writes the control word with bit 31 set and then clear (CFG register),
// streams N_WORDS sequence words into the data FIFO register, polls the
// status register until bit 0 is set, then reads the result register.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-low reset
//   start_i, cfg_i            job request pulse (sampled in IDLE) and control word
//   word_valid_i/word_i       sequence-word stream; transfer on valid & word_ready_o
//   wbm_*_o, wbm_dat_i/ack_i  Wishbone classic master
//   result_o/result_valid_o   captured result and its one-cycle strobe
//   busy_o, err_o             job in progress / last job hit an ack timeout
//   dbg_state_o               current FSM state
//
// Handshake: a word moves on a rising edge where word_valid_i and word_ready_o
// are both high. word_ready_o depends only on registers, never on word_valid_i.
module wb_calc_e_host #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned N_WORDS     = 4,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] cfg_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output logic        word_ready_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG_SET = 3'd1,
    S_CFG_CLR = 3'd2,
    S_LOAD    = 3'd3,
    S_POLL    = 3'd4,
    S_GAP     = 3'd5,
    S_READ    = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  localparam logic [7:0]  WORD_LAST = 8'(N_WORDS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);
  localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);

  state_e      state_q;
  logic [30:0] cfg_q;
  logic        cyc_q, we_q, result_valid_q, err_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q, result_q;
  logic [7:0]  word_cnt_q, gap_cnt_q;
  logic [15:0] tmo_cnt_q;

  // Bus cycle the current state wants to open next.
  logic        open_d, we_d;
  logic [31:0] adr_d, dat_d;

  // Bit 31 of the control word is always supplied by the block itself.
  logic cfg_msb_unused;
  assign cfg_msb_unused = cfg_i[31];

  always_comb begin
    open_d = 1'b0;
    we_d   = 1'b0;
    adr_d  = BASE_ADDR;
    dat_d  = '0;
    case (state_q)
      S_CFG_SET: begin open_d = 1'b1; we_d = 1'b1; adr_d = BASE_ADDR + 32'h08; dat_d = {1'b1, cfg_q}; end
      S_CFG_CLR: begin open_d = 1'b1; we_d = 1'b1; adr_d = BASE_ADDR + 32'h08; dat_d = {1'b0, cfg_q}; end
      // In LOAD, opening the write is the act of accepting the word.
      S_LOAD:    begin open_d = word_valid_i; we_d = 1'b1; adr_d = BASE_ADDR + 32'h10; dat_d = word_i; end
      S_POLL:    begin open_d = 1'b1; adr_d = BASE_ADDR; end
      S_READ:    begin open_d = 1'b1; adr_d = BASE_ADDR + 32'h0C; end
      default:   ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q        <= S_IDLE;
      cfg_q          <= '0;
      cyc_q          <= 1'b0;
      we_q           <= 1'b0;
      sel_q          <= '0;
      adr_q          <= '0;
      dat_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      word_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cfg_q      <= cfg_i[30:0];
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            state_q    <= S_CFG_SET;
          end
        end
        S_GAP: begin
          gap_cnt_q <= gap_cnt_q + 8'd1;
          if (gap_cnt_q == GAP_LAST) state_q <= S_POLL;
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          if (!cyc_q) begin
            // Entering a bus state always happens with cyc low, which
            // guarantees the idle cycle between consecutive bus cycles.
            if (open_d) begin
              cyc_q     <= 1'b1;
              we_q      <= we_d;
              sel_q     <= 4'hF;
              adr_q     <= adr_d;
              dat_q     <= dat_d;
              tmo_cnt_q <= '0;
            end
          end else if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            case (state_q)
              S_CFG_SET: state_q <= S_CFG_CLR;
              S_CFG_CLR: state_q <= S_LOAD;
              S_LOAD: begin
                if (word_cnt_q == WORD_LAST) state_q <= S_POLL;
                else word_cnt_q <= word_cnt_q + 8'd1;
              end
              S_POLL: begin
                if (wbm_dat_i[0]) state_q <= S_READ;
                else if (POLL_GAP == 0) state_q <= S_POLL;
                else begin
                  gap_cnt_q <= '0;
                  state_q   <= S_GAP;
                end
              end
              S_READ: begin
                result_q       <= wbm_dat_i;
                result_valid_q <= 1'b1;
                state_q        <= S_DONE;
              end
              default: ;
            endcase
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Slave never answered: abandon the job without a result.
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign word_ready_o   = (state_q == S_LOAD) && !cyc_q;
  assign wbm_cyc_o      = cyc_q;
  assign wbm_stb_o      = cyc_q;
  assign wbm_we_o       = we_q;
  assign wbm_sel_o      = sel_q;
  assign wbm_adr_o      = adr_q;
  assign wbm_dat_o      = dat_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign err_o          = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_wb_calc_e_host.sv
module tb_wb_calc_e_host;
  localparam logic [31:0] BASE = 32'h3000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, word_valid, word_ready, ack;
  logic [31:0] cfg, word, rdat;
  logic        cyc, stb, we, rv, busy, err;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, result;
  logic [2:0]  dbg_state;

  wb_calc_e_host dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start), .cfg_i(cfg),
    .word_valid_i(word_valid), .word_i(word), .word_ready_o(word_ready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(rdat), .wbm_ack_i(ack),
    .result_o(result), .result_valid_o(rv), .busy_o(busy), .err_o(err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];      // {we, adr, dat} of each expected bus cycle
  logic [31:0] exp_res_q[$];  // expected result_o at each result_valid_o

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- slave model + bus monitor ----------------
  bit          lat_rand = 0;
  logic        block_en = 0;
  logic [31:0] block_adr = '0;
  logic [31:0] res_val = '0;
  int          poll_total = 0;
  int          ready_at = 0;
  int          wait_cnt, cur_lat;
  logic        prev_cyc, prev_acked, unstable;
  logic [69:0] prev_bus, bus;
  logic [64:0] e;

  always @(negedge clk) begin
    ack  = 1'b0;
    rdat = '0;
    if (!rst_n) begin
      prev_cyc = 0; prev_acked = 0; unstable = 0; wait_cnt = 0;
    end else begin
      if (prev_acked) chk("drop_after_ack", cyc, 0);
      prev_acked = 0;
      bus = {stb, we, sel, adr, dat_o};
      if (cyc && !prev_cyc) begin
        unstable = 0;
        wait_cnt = 0;
        cur_lat  = lat_rand ? int'($urandom_range(0, 5)) : 0;
      end else if (cyc && bus != prev_bus) begin
        unstable = 1;
      end
      if (cyc && !(block_en && adr == block_adr)) begin
        if (wait_cnt >= cur_lat) begin
          ack = 1'b1;
          if (adr == BASE) begin
            poll_total++;
            rdat = (poll_total >= ready_at) ? 32'h0000_0001 : 32'hFFFF_FFFE;
          end else if (adr == BASE + 32'h0C) begin
            rdat = res_val;
          end
          chk("bus_stable_sel", {unstable, stb, sel}, {1'b0, 1'b1, 4'hF});
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bus_txn: actual=%0h required=none", {we, adr, dat_o});
          end else begin
            e = exp_q.pop_front();
            chk("bus_txn", {we, adr, dat_o}, e);
          end
          prev_acked = 1;
        end else begin
          wait_cnt++;
        end
      end
      prev_cyc = cyc;
      prev_bus = bus;
    end
  end

  logic prev_rv = 0;
  always @(negedge clk) begin
    if (rst_n && rv) begin
      chk("rv_one_cycle", prev_rv, 0);
      if (exp_res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: actual=%0h required=none", result);
      end else begin
        chk("result", result, exp_res_q.pop_front());
      end
    end
    prev_rv = rst_n && rv;
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [31:0] c, input logic [31:0] wbase,
                          input int n_polls, input bit with_result);
    logic [31:0] cv;
    cv = c;
    ready_at = poll_total + n_polls;
    exp_q.push_back({1'b1, BASE + 32'h08, {1'b1, cv[30:0]}});
    exp_q.push_back({1'b1, BASE + 32'h08, {1'b0, cv[30:0]}});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, BASE + 32'h10, wbase + 32'(i)});
    for (int i = 0; i < n_polls; i++) exp_q.push_back({1'b0, BASE, 32'h0});
    if (with_result) begin
      exp_q.push_back({1'b0, BASE + 32'h0C, 32'h0});
      exp_res_q.push_back(res_val);
    end
  endtask

  task automatic pulse_start(input logic [31:0] c);
    start = 1'b1;
    cfg   = c;
    @(negedge clk);
    start = 1'b0;
    cfg   = 32'h0BAD_0BAD;
  endtask

  task automatic feed_words(input logic [31:0] wbase, input int stall_at);
    int n, seen;
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        n = 0;
        while (cyc && n < 50) begin @(negedge clk); n++; end
        seen = 0;
        repeat (20) begin @(negedge clk); if (cyc) seen++; end
        chk("stall_no_bus", seen, 0);
      end
      word_valid = 1'b1;
      word = wbase + 32'(i);
      n = 0;
      while (!word_ready && n < 300) begin @(negedge clk); n++; end
      chk("word_ready_seen", word_ready, 1);
      @(negedge clk);
      word_valid = 1'b0;
      word = 32'h0;
    end
  endtask

  task automatic wait_rv(input string name);
    int n;
    n = 0;
    while (!rv && n < 1000) begin @(negedge clk); n++; end
    chk(name, rv, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    chk(name, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {cyc, stb, we, sel, rv, busy, err, word_ready, dbg_state}, 0);
    chk({name, "_adr_dat"}, {adr, dat_o}, 0);
    chk({name, "_result"}, result, 0);
  endtask

  // ---------------- stimulus ----------------
  int n, hi;

  initial begin
    start = 0; cfg = 0; word_valid = 0; word = 0; ack = 0; rdat = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // Full job, zero-wait slave, ready on the 4th poll.
    res_val = 32'h1234_5678;
    push_job(32'h0000_002C, 32'h0000_BEEF, 4, 1);
    pulse_start(32'h0000_002C);
    feed_words(32'h0000_BEEF, -1);
    wait_idle("job1_idle");
    chk("job1_result_hold", result, 32'h1234_5678);
    chk("job1_err", err, 0);

    // Random ack latency, bit 31 of cfg_i must be overridden.
    lat_rand = 1;
    res_val  = 32'hCAFE_F00D;
    push_job(32'hFFFF_FFAC, 32'h0000_1000, 2, 1);
    pulse_start(32'hFFFF_FFAC);
    feed_words(32'h0000_1000, -1);
    wait_idle("job2_idle");

    // Word stream stalls mid-LOAD.
    lat_rand = 0;
    res_val  = 32'h0000_0001;
    push_job(32'h0000_0015, 32'h0000_A0A0, 1, 1);
    pulse_start(32'h0000_0015);
    feed_words(32'h0000_A0A0, 2);
    wait_idle("job3_idle");

    // Slave never acks the CFG_SET write.
    block_en = 1; block_adr = BASE + 32'h08;
    start = 1'b1; cfg = 32'h0000_002C;
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (cyc) hi++;
    end while (busy && n < 200);
    chk("tmo_stb_cycles", hi, 64);
    chk("tmo_busy_cycles", n, 66);
    chk("tmo_state", {err, busy, cyc, stb}, 4'b1000);
    repeat (3) @(negedge clk);
    chk("tmo_err_held", err, 1);
    block_en = 0;
    res_val  = 32'h5555_AAAA;
    push_job(32'h0000_0003, 32'h0000_0300, 1, 1);
    pulse_start(32'h0000_0003);
    chk("err_cleared_on_start", err, 0);
    feed_words(32'h0000_0300, -1);
    wait_idle("job4_idle");

    // Reset while a status poll is open.
    block_en = 1; block_adr = BASE;
    push_job(32'h0000_0042, 32'h0000_4200, 0, 0);
    pulse_start(32'h0000_0042);
    feed_words(32'h0000_4200, -1);
    n = 0;
    while (!(cyc && adr == BASE) && n < 300) begin @(negedge clk); n++; end
    chk("poll_open", {cyc, adr}, {1'b1, BASE});
    rst_n = 0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1;
    block_en = 0;
    chk("queue_drained_at_reset", exp_q.size(), 0);
    @(negedge clk);
    res_val = 32'h0BAD_F00D;
    push_job(32'h0000_0007, 32'h0000_0700, 2, 1);
    pulse_start(32'h0000_0007);
    feed_words(32'h0000_0700, -1);
    wait_idle("job5_idle");

    // start_i while busy and in DONE is ignored.
    res_val = 32'h1111_2222;
    push_job(32'h0000_0011, 32'h0000_1100, 1, 1);
    pulse_start(32'h0000_0011);
    pulse_start(32'h0000_0077);
    feed_words(32'h0000_1100, -1);
    wait_rv("job6_rv");
    pulse_start(32'h0000_0099);
    repeat (3) @(negedge clk);
    chk("start_in_done_ignored", busy, 0);

    // start_i in the first IDLE cycle after DONE begins the next job.
    res_val = 32'h3333_4444;
    push_job(32'h0000_0022, 32'h0000_2200, 1, 1);
    pulse_start(32'h0000_0022);
    feed_words(32'h0000_2200, -1);
    wait_rv("job7_rv");
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    res_val = 32'h5555_6666;
    push_job(32'h0000_0033, 32'h0000_3300, 1, 1);
    pulse_start(32'h0000_0033);
    chk("start_in_idle_accepted", busy, 1);
    feed_words(32'h0000_3300, -1);
    wait_idle("job8_idle");

    repeat (5) @(negedge clk);
    chk("bus_queue_empty", exp_q.size(), 0);
    chk("result_queue_empty", exp_res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_calc_e_host.md
WB_CALC_E_HOST -- requirements
Module: wb_calc_e_host

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte address of the calc_e register block.
REQ-002 SHALL have parameter N_WORDS, default 4, count of sequence words written per job (1..255).
REQ-003 SHALL have parameter POLL_GAP, default 8, idle cycles between status polls (0..255).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 64, cycles a single bus cycle may wait for ack (1..65535).
REQ-005 SHALL have port wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports start_i in 1 and cfg_i in 32: job request pulse and control word (bit 31 ignored, forced by block).
REQ-008 SHALL have ports word_valid_i in 1, word_i in 32, word_ready_o out 1: sequence-word stream, transfer on valid&ready.
REQ-009 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32: Wishbone classic master outputs.
REQ-010 SHALL have ports wbm_dat_i in 32, wbm_ack_i in 1: Wishbone read data and ack.
REQ-011 SHALL have ports result_o out 32, result_valid_o out 1, busy_o out 1, err_o out 1.

Function
REQ-012 SHALL implement states IDLE, CFG_SET, CFG_CLR, LOAD, POLL, GAP, READ, DONE.
REQ-013 SHALL in IDLE, on start_i=1, latch cfg_i, clear err_o, go CFG_SET next cycle; start_i ignored outside IDLE.
REQ-014 SHALL in CFG_SET write {1'b1, cfg[30:0]} to BASE_ADDR+0x08; CFG_CLR then writes {1'b0, cfg[30:0]} to the same address.
REQ-015 SHALL in LOAD write each accepted word_i to BASE_ADDR+0x10, N_WORDS times, then go POLL.
REQ-016 SHALL assert word_ready_o only in LOAD with no bus cycle open; accepted word starts a write on the next cycle.
REQ-017 SHALL in POLL read BASE_ADDR+0x00; wbm_dat_i[0]=1 at ack -> READ, else -> GAP for POLL_GAP cycles, then POLL.
REQ-018 SHALL in READ read BASE_ADDR+0x0C, capture wbm_dat_i into result_o at ack, go DONE.
REQ-019 SHALL in DONE pulse result_valid_o high exactly one cycle, then return to IDLE; result_o holds until next capture.
REQ-020 SHALL drive each bus cycle registered: cyc,stb,we,adr,dat,sel=4'hF rise together, hold stable until ack sampled high.
REQ-021 SHALL drop cyc and stb the cycle after ack, with at least one idle cycle (cyc=0) between consecutive bus cycles.
REQ-022 SHALL drive wbm_we_o=1 for CFG_SET/CFG_CLR/LOAD cycles, 0 for POLL/READ; wbm_dat_o=0 during reads.
REQ-023 SHALL count cycles with stb high and ack low; at ACK_TIMEOUT, drop cyc/stb, set err_o=1, return to IDLE without result_valid_o.
REQ-024 SHALL keep err_o set until the next accepted start_i.
REQ-025 SHALL assert busy_o in every state except IDLE.
REQ-026 SHALL ignore wbm_ack_i when no cycle is open.
REQ-027 SHALL allow a new start_i in the cycle IDLE is re-entered after DONE.

Reset
REQ-028 SHALL on wb_rst_i=0 at a clock edge go IDLE and zero all outputs (cyc, stb, we, adr, dat, result_o, result_valid_o, busy_o, err_o, word_ready_o); wbm_sel_o=0.
REQ-029 SHALL abort any open bus cycle on reset mid-operation, dropping cyc/stb on the reset edge; no partial result is reported.

Verification
REQ-030 Full job: cfg_i=0x2C, words BEEF,BEF0,BEF1,BEF2, slave sets status bit0 after 3 polls, result 0x1234_5678 -> writes 0x8000002C,0x0000002C @0x08, four writes @0x10, 4 reads @0x00, read @0x0C, result_valid_o one cycle with 0x12345678.
REQ-031 Ack latency 0..5 wait cycles randomized per cycle -> all addr/data stable while stb high, one idle cycle between cycles, same result.
REQ-032 Slave never acks CFG_SET -> after 64 cycles cyc/stb=0, err_o=1, busy_o=0, no result_valid_o; next start_i clears err_o.
REQ-033 word_valid_i stalled 20 cycles mid-LOAD -> no bus cycle during stall, word count still exactly 4.
REQ-034 Reset asserted while POLL read open -> next cycle all outputs 0, state IDLE; subsequent job completes normally.
REQ-035 start_i pulsed while busy and in DONE cycle -> ignored; pulsed first cycle back in IDLE -> new job begins.
